// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I main decoder.
// One-entry valid/ready pipeline register between fetch and execute.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic             reg_write,
  output logic             mem_write,
  output logic             branch,
  output logic             jump,
  output logic             alu_src,
  output logic             alu_a_pc,
  output logic             illegal,
  output logic [2:0]       imm_src,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       alu_a_pc;
    logic       illegal;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctl_t;

  state_t          r_state;
  state_t          w_state_nxt;
  ctl_t            r_ctl;
  ctl_t            w_ctl;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] w_imm;
  logic [31:0]     w_imm32;
  logic [CNT_W-1:0] r_cnt;
  logic            w_accept;
  logic            w_load;

  assign out_valid = (r_state == FULL);
  assign in_ready  = !rst && (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_load    = w_accept && !flush;

  // Main opcode decode into control bundle
  always_comb begin
    w_ctl = '0;
    unique case (in_instr[6:0])
      7'b0000011: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.alu_src    = 1'b1;
        w_ctl.result_src = 2'b01;
        w_ctl.imm_src    = 3'b000;
      end
      7'b0100011: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.alu_src   = 1'b1;
        w_ctl.imm_src   = 3'b001;
      end
      7'b0110011: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.alu_op    = 2'b10;
      end
      7'b0010011: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.alu_src   = 1'b1;
        w_ctl.alu_op    = 2'b10;
        w_ctl.imm_src   = 3'b000;
      end
      7'b1100011: begin
        w_ctl.branch  = 1'b1;
        w_ctl.alu_op  = 2'b01;
        w_ctl.imm_src = 3'b010;
      end
      7'b1101111: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.jump       = 1'b1;
        w_ctl.result_src = 2'b10;
        w_ctl.imm_src    = 3'b011;
      end
      7'b1100111: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.jump       = 1'b1;
        w_ctl.alu_src    = 1'b1;
        w_ctl.result_src = 2'b10;
        w_ctl.imm_src    = 3'b000;
      end
      7'b0110111: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.alu_src    = 1'b1;
        w_ctl.result_src = 2'b11;
        w_ctl.imm_src    = 3'b100;
      end
      7'b0010111: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.alu_src   = 1'b1;
        w_ctl.alu_a_pc  = 1'b1;
        w_ctl.imm_src   = 3'b100;
      end
      7'b0000000: begin
        w_ctl = '0;
      end
      default: begin
        w_ctl.illegal = 1'b1;
      end
    endcase
  end

  // Immediate assembly by format, then sign extension to XLEN
  always_comb begin
    w_imm32 = '0;
    unique case (w_ctl.imm_src)
      3'b001:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                          in_instr[11:7]};
      3'b010:  w_imm32 = {{20{in_instr[31]}}, in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      3'b011:  w_imm32 = {{12{in_instr[31]}}, in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      3'b100:  w_imm32 = {in_instr[31:12], 12'b0};
      default: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    endcase
    w_imm        = {XLEN{w_imm32[31]}};
    w_imm[31:0]  = w_imm32;
  end

  // EMPTY/FULL next state; flush always empties the stage
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: if (w_accept) w_state_nxt = FULL;
      FULL:  if (out_ready && !w_accept) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) w_state_nxt = EMPTY;
  end

  // Pipeline register, state and saturating illegal counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_ctl   <= '0;
      r_instr <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_ctl   <= w_ctl;
        r_instr <= in_instr;
        r_pc    <= in_pc;
        r_imm   <= w_imm;
      end
      if (w_load && w_ctl.illegal && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_instr   = r_instr;
  assign out_pc      = r_pc;
  assign out_imm     = r_imm;
  assign reg_write   = r_ctl.reg_write & out_valid;
  assign mem_write   = r_ctl.mem_write & out_valid;
  assign branch      = r_ctl.branch & out_valid;
  assign jump        = r_ctl.jump & out_valid;
  assign illegal     = r_ctl.illegal & out_valid;
  assign alu_src     = r_ctl.alu_src;
  assign alu_a_pc    = r_ctl.alu_a_pc;
  assign imm_src     = r_ctl.imm_src;
  assign result_src  = r_ctl.result_src;
  assign alu_op      = r_ctl.alu_op;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage.
// XLEN=64, CNT_W=2 so sign extension and saturation are visible.
module tb_decode_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_imm;
  logic             reg_write;
  logic             mem_write;
  logic             branch;
  logic             jump;
  logic             alu_src;
  logic             alu_a_pc;
  logic             illegal;
  logic [2:0]       imm_src;
  logic [1:0]       result_src;
  logic [1:0]       alu_op;
  logic [CNT_W-1:0] illegal_cnt;

  int n_vec;
  int n_err;

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
    .reg_write(reg_write), .mem_write(mem_write),
    .branch(branch), .jump(jump),
    .alu_src(alu_src), .alu_a_pc(alu_a_pc),
    .illegal(illegal), .imm_src(imm_src),
    .result_src(result_src), .alu_op(alu_op),
    .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h0000_007F;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_cnt", 64'(illegal_cnt), 64'd0);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);

    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // lw x1,4(x2)
    in_valid = 1'b1;
    in_instr = 32'h0041_2083;
    in_pc    = 64'h100;
    tick();
    chk("lw_valid", 64'(out_valid), 64'd1);
    chk("lw_regw", 64'(reg_write), 64'd1);
    chk("lw_alusrc", 64'(alu_src), 64'd1);
    chk("lw_res", 64'(result_src), 64'd1);
    chk("lw_imm", out_imm, 64'd4);
    chk("lw_pc", out_pc, 64'h100);
    chk("lw_isrc", 64'(imm_src), 64'd0);

    // lui x0,0x80000
    in_instr = 32'h8000_0037;
    in_pc    = 64'h104;
    tick();
    chk("lui_isrc", 64'(imm_src), 64'd4);
    chk("lui_res", 64'(result_src), 64'd3);
    chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_apc", 64'(alu_a_pc), 64'd0);

    // auipc x1,1
    in_instr = 32'h0000_1097;
    in_pc    = 64'h108;
    tick();
    chk("auipc_apc", 64'(alu_a_pc), 64'd1);
    chk("auipc_imm", out_imm, 64'h1000);
    chk("auipc_res", 64'(result_src), 64'd0);

    // backpressure with addi x3,x0,5 waiting
    out_ready = 1'b0;
    in_instr  = 32'h0050_0193;
    in_pc     = 64'h10C;
    #1;
    chk("bp_ready0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_instr", 64'(out_instr), 64'h0000_1097);
      chk("bp_imm", out_imm, 64'h1000);
    end
    out_ready = 1'b1;
    #1;
    chk("rel_ready", 64'(in_ready), 64'd1);
    tick();
    chk("rel_instr", 64'(out_instr), 64'h0050_0193);
    chk("rel_imm", out_imm, 64'd5);
    chk("rel_aluop", 64'(alu_op), 64'd2);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_regw", 64'(reg_write), 64'd0);

    // beq x0,x0,8 accepted together with flush
    in_valid = 1'b1;
    in_instr = 32'h0000_0463;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_branch", 64'(branch), 64'd0);
    chk("fl_cnt", 64'(illegal_cnt), 64'd0);

    // beq accepted, then flushed while held
    tick();
    chk("beq_branch", 64'(branch), 64'd1);
    chk("beq_aluop", 64'(alu_op), 64'd1);
    chk("beq_isrc", 64'(imm_src), 64'd2);
    chk("beq_imm", out_imm, 64'd8);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b1;
    chk("flf_valid", 64'(out_valid), 64'd0);
    chk("flf_branch", 64'(branch), 64'd0);

    // illegal opcode stream, counter saturates at 3
    in_valid = 1'b1;
    in_instr = 32'h0000_007F;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("ill_flag", 64'(illegal), 64'd1);
      chk("ill_cnt", 64'(illegal_cnt), 64'(i > 3 ? 3 : i));
    end

    // bubble
    in_instr = 32'h0000_0000;
    tick();
    chk("bub_valid", 64'(out_valid), 64'd1);
    chk("bub_ill", 64'(illegal), 64'd0);
    chk("bub_regw", 64'(reg_write), 64'd0);
    chk("bub_cnt", 64'(illegal_cnt), 64'd3);

    // jal x1,-4
    in_instr = 32'hFFDF_F0EF;
    tick();
    chk("jal_jump", 64'(jump), 64'd1);
    chk("jal_res", 64'(result_src), 64'd2);
    chk("jal_isrc", 64'(imm_src), 64'd3);
    chk("jal_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

    // sw x5,12(x2), then hold it
    in_instr = 32'h0051_2623;
    tick();
    chk("sw_memw", 64'(mem_write), 64'd1);
    chk("sw_regw", 64'(reg_write), 64'd0);
    chk("sw_isrc", 64'(imm_src), 64'd1);
    chk("sw_imm", out_imm, 64'd12);

    // reset while FULL
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rstf_ready", 64'(in_ready), 64'd0);
    tick();
    chk("rstf_valid", 64'(out_valid), 64'd0);
    chk("rstf_cnt", 64'(illegal_cnt), 64'd0);
    chk("rstf_imm", out_imm, 64'd0);
    chk("rstf_instr", 64'(out_instr), 64'd0);
    chk("rstf_memw", 64'(mem_write), 64'd0);
    chk("rstf_isrc", 64'(imm_src), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rstf_ready1", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
